// File: rtl/data_memory_handshake.sv
// Multi-cycle data memory with a req/ready + resp_valid handshake for the MIPS memory stage.
// Fixed access latency, byte-enable writes, and error responses for misaligned or out-of-range addresses.
//   state | meaning
//   IDLE  | waiting for a request, ready=1
//   BUSY  | access in flight, latency counter running, ready=0
//   RESP  | response strobe this cycle, ready=1 so the next request needs no bubble
module data_memory_handshake #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4096,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req,
  output logic                ready,
  input  logic                wen,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  input  logic [DATA_W/8-1:0] be,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   dout,
  output logic                err
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 5;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
    $error("data_memory_handshake: LATENCY must be in 1..16");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("data_memory_handshake: DATA_W must be a multiple of 8");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("data_memory_handshake: DEPTH must be a power of two");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  logic              c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_din;
  logic [NB-1:0]     c_be;

  logic              a_wen;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [NB-1:0]     a_be;
  logic              do_access;
  logic              bad;
  logic [IDX_W-1:0]  idx;

  assign accept = req & ready;

  // With LATENCY=1 the access happens on the accept edge itself, so use the live request fields.
  always_comb begin
    a_wen     = c_wen;
    a_addr    = c_addr;
    a_din     = c_din;
    a_be      = c_be;
    do_access = (state == BUSY) && (cnt == CNT_W'(1));
    if (LATENCY == 1) begin
      a_wen     = wen;
      a_addr    = addr;
      a_din     = din;
      a_be      = be;
      do_access = accept;
    end
  end

  assign bad = (|(a_addr & OFF_MASK)) | (|(a_addr >> (OFF_W + IDX_W)));
  assign idx = a_addr[OFF_W +: IDX_W];

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE, RESP: begin
        if (accept) state_nxt = (LATENCY == 1) ? RESP : BUSY;
        else        state_nxt = IDLE;
      end
      BUSY:    state_nxt = (cnt == CNT_W'(1)) ? RESP : BUSY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ready      <= 1'b0;
      resp_valid <= 1'b0;
      dout       <= '0;
      err        <= 1'b0;
      c_wen      <= 1'b0;
      c_addr     <= '0;
      c_din      <= '0;
      c_be       <= '0;
    end else begin
      state <= state_nxt;
      ready <= (state_nxt != BUSY);
      if (accept) begin
        cnt    <= CNT_W'(LATENCY - 1);
        c_wen  <= wen;
        c_addr <= addr;
        c_din  <= din;
        c_be   <= be;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
      end
      resp_valid <= do_access;
      err        <= do_access & bad;
      dout       <= (do_access && !bad && !a_wen) ? mem[idx] : '0;
    end
  end

  // Array has no reset; a reset aborts the access because do_access depends on reset state.
  always_ff @(posedge clock) begin
    if (do_access && a_wen && !bad) begin
      for (int i = 0; i < NB; i++) begin
        if (a_be[i]) mem[idx][8*i +: 8] <= a_din[8*i +: 8];
      end
    end
  end

endmodule
